// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared opcode, control encodings and FSM states for the multicycle CPU
package cpu_defs_pkg;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;

   // ALUOp is also consumed by the ALU control block
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_EXEC   = 4'd6,
      ST_RWB    = 4'd7,
      ST_BRANCH = 4'd8,
      ST_JUMP   = 4'd9
   } state_t;

endpackage

// File: rtl/opcode_class.sv
// rtl/opcode_class.sv - combinational opcode classifier
// MC_JUMP_EN: when undefined, j is classified as illegal.
module opcode_class
   import cpu_defs_pkg::*;
(
   input  logic [5:0] i_opcode,
   output logic       o_is_r,
   output logic       o_is_lw,
   output logic       o_is_sw,
   output logic       o_is_beq,
   output logic       o_is_j,
   output logic       o_is_illegal
);

   assign o_is_r   = (i_opcode == OP_R);
   assign o_is_lw  = (i_opcode == OP_LW);
   assign o_is_sw  = (i_opcode == OP_SW);
   assign o_is_beq = (i_opcode == OP_BEQ);
`ifdef MC_JUMP_EN
   assign o_is_j   = (i_opcode == OP_J);
`else
   assign o_is_j   = 1'b0;
`endif
   assign o_is_illegal = ~(o_is_r | o_is_lw | o_is_sw | o_is_beq | o_is_j);

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the multicycle datapath
// MC_JUMP_EN: enables the JUMP state for opcode j.
module multicycle_control
   import cpu_defs_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic             pc_en,
   output logic             instr_done,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_count
);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_count;

   logic w_is_r, w_is_lw, w_is_sw, w_is_beq, w_is_j, w_is_illegal;
   logic w_pcwrite, w_pcwritecond, w_iord, w_memread, w_memwrite, w_irwrite;
   logic w_memtoreg, w_regdst, w_regwrite, w_alusrca, w_done, w_illegal;
   logic [1:0] w_alusrcb, w_aluop, w_pcsource;

   opcode_class u_opcode_class (
      .i_opcode     (opcode),
      .o_is_r       (w_is_r),
      .o_is_lw      (w_is_lw),
      .o_is_sw      (w_is_sw),
      .o_is_beq     (w_is_beq),
      .o_is_j       (w_is_j),
      .o_is_illegal (w_is_illegal)
   );

   always_comb begin
      w_next        = r_state;
      w_pcwrite     = 1'b0;
      w_pcwritecond = 1'b0;
      w_iord        = 1'b0;
      w_memread     = 1'b0;
      w_memwrite    = 1'b0;
      w_irwrite     = 1'b0;
      w_memtoreg    = 1'b0;
      w_regdst      = 1'b0;
      w_regwrite    = 1'b0;
      w_alusrca     = 1'b0;
      w_alusrcb     = SRCB_REG;
      w_aluop       = ALUOP_ADD;
      w_pcsource    = PCSRC_ALU;
      w_done        = 1'b0;
      w_illegal     = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_memread = 1'b1;
            w_alusrcb = SRCB_FOUR;
            w_irwrite = mem_ready;
            w_pcwrite = mem_ready;
            if (mem_ready) w_next = ST_DECODE;
         end
         ST_DECODE: begin
            w_alusrcb = SRCB_IMMSH2;
            if (w_is_illegal) begin
               w_illegal = 1'b1;
               w_next    = ST_FETCH;
            end
            else if (w_is_lw || w_is_sw) w_next = ST_MEMADR;
            else if (w_is_r)             w_next = ST_EXEC;
            else if (w_is_beq)           w_next = ST_BRANCH;
            else if (w_is_j)             w_next = ST_JUMP;
            else                         w_next = ST_FETCH;
         end
         ST_MEMADR: begin
            w_alusrca = 1'b1;
            w_alusrcb = SRCB_IMM;
            w_next    = w_is_lw ? ST_MEMRD : ST_MEMWR;
         end
         ST_MEMRD: begin
            w_memread = 1'b1;
            w_iord    = 1'b1;
            if (mem_ready) w_next = ST_MEMWB;
         end
         ST_MEMWB: begin
            w_regwrite = 1'b1;
            w_memtoreg = 1'b1;
            w_done     = 1'b1;
            w_next     = ST_FETCH;
         end
         ST_MEMWR: begin
            w_memwrite = 1'b1;
            w_iord     = 1'b1;
            w_done     = mem_ready;
            if (mem_ready) w_next = ST_FETCH;
         end
         ST_EXEC: begin
            w_alusrca = 1'b1;
            w_aluop   = ALUOP_RTYPE;
            w_next    = ST_RWB;
         end
         ST_RWB: begin
            w_regwrite = 1'b1;
            w_regdst   = 1'b1;
            w_done     = 1'b1;
            w_next     = ST_FETCH;
         end
         ST_BRANCH: begin
            w_alusrca     = 1'b1;
            w_aluop       = ALUOP_SUB;
            w_pcwritecond = 1'b1;
            w_pcsource    = PCSRC_ALUOUT;
            w_done        = 1'b1;
            w_next        = ST_FETCH;
         end
`ifdef MC_JUMP_EN
         ST_JUMP: begin
            w_pcwrite  = 1'b1;
            w_pcsource = PCSRC_JUMP;
            w_done     = 1'b1;
            w_next     = ST_FETCH;
         end
`endif
         default: w_next = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_FETCH;
         r_count <= '0;
      end
      else begin
         r_state <= w_next;
         if (w_done) r_count <= r_count + CNT_W'(1);
      end
   end

   // Reset forces every control low combinationally, so an abort drops write enables at once
   assign PCWrite     = ~rst & w_pcwrite;
   assign PCWriteCond = ~rst & w_pcwritecond;
   assign IorD        = ~rst & w_iord;
   assign MemRead     = ~rst & w_memread;
   assign MemWrite    = ~rst & w_memwrite;
   assign IRWrite     = ~rst & w_irwrite;
   assign MemtoReg    = ~rst & w_memtoreg;
   assign RegDst      = ~rst & w_regdst;
   assign RegWrite    = ~rst & w_regwrite;
   assign ALUSrcA     = ~rst & w_alusrca;
   assign ALUSrcB     = rst ? 2'b00 : w_alusrcb;
   assign ALUOp       = rst ? 2'b00 : w_aluop;
   assign PCSource    = rst ? 2'b00 : w_pcsource;
   assign pc_en       = ~rst & (w_pcwrite | (w_pcwritecond & zero));
   assign instr_done  = ~rst & w_done;
   assign illegal_op  = ~rst & w_illegal;
   assign instr_count = rst ? '0 : r_count;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

   localparam int CW = 4;

   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,pc_en,instr_done,illegal_op}
   localparam logic [18:0] V_ZERO   = 19'b0;
   localparam logic [18:0] V_FETCH  = 19'b1_0_0_1_0_1_0_0_0_0_01_00_00_1_0_0;
   localparam logic [18:0] V_FSTALL = 19'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0_0;
   localparam logic [18:0] V_DEC    = 19'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0_0;
   localparam logic [18:0] V_DECILL = 19'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0_1;
   localparam logic [18:0] V_MADR   = 19'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0_0;
   localparam logic [18:0] V_MRD    = 19'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0_0;
   localparam logic [18:0] V_MWB    = 19'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_1_0;
   localparam logic [18:0] V_MWR    = 19'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_1_0;
   localparam logic [18:0] V_MWRST  = 19'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0_0;
   localparam logic [18:0] V_EXEC   = 19'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0_0;
   localparam logic [18:0] V_RWB    = 19'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_1_0;
   localparam logic [18:0] V_BRZ    = 19'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_1_0;
   localparam logic [18:0] V_BRN    = 19'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_1_0;
   localparam logic [18:0] V_JMP    = 19'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_1_0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [5:0] opcode = 6'b0;
   logic zero = 1'b0;
   logic mem_ready = 1'b0;
   logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic MemtoReg, RegDst, RegWrite, ALUSrcA, pc_en, instr_done, illegal_op;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [CW-1:0] instr_count;

   int checks = 0;
   int failures = 0;
   logic [CW-1:0] exp_cnt = '0;

   wire [18:0] obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                      RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, pc_en,
                      instr_done, illegal_op};

   always #5 clk = ~clk;

   multicycle_control #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .pc_en(pc_en), .instr_done(instr_done),
      .illegal_op(illegal_op), .instr_count(instr_count)
   );

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs !== V_ZERO) begin
         failures++;
         $display("FAIL reset_outputs got=%b want=%b", obs, V_ZERO);
      end
      checks++;
      if (instr_count !== '0) begin
         failures++;
         $display("FAIL reset_count got=%0d want=0", instr_count);
      end
      @(negedge clk);
      rst = 1'b0;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (obs !== V_FSTALL) begin
         failures++;
         $display("FAIL reset_release_fetch got=%b want=%b", obs, V_FSTALL);
      end
      exp_cnt = '0;
   endtask

   task automatic test_rtype;
      logic [18:0] e[4];
      e = '{V_FETCH, V_DEC, V_EXEC, V_RWB};
      opcode = 6'b000000;
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (obs !== e[i]) begin
            failures++;
            $display("FAIL rtype_cycle%0d got=%b want=%b", i, obs, e[i]);
         end
         @(posedge clk);
         #1;
      end
      exp_cnt = exp_cnt + 1'b1;
      checks++;
      if (instr_count !== exp_cnt) begin
         failures++;
         $display("FAIL rtype_count got=%0d want=%0d", instr_count, exp_cnt);
      end
   endtask

   task automatic test_lw_stall;
      logic [18:0] e[7];
      logic        mr[7];
      e  = '{V_FETCH, V_DEC, V_MADR, V_MRD, V_MRD, V_MRD, V_MWB};
      mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      opcode = 6'b100011;
      for (int i = 0; i < 7; i++) begin
         mem_ready = mr[i];
         #1;
         checks++;
         if (obs !== e[i]) begin
            failures++;
            $display("FAIL lw_cycle%0d got=%b want=%b", i, obs, e[i]);
         end
         @(posedge clk);
         #1;
      end
      exp_cnt = exp_cnt + 1'b1;
      checks++;
      if (instr_count !== exp_cnt) begin
         failures++;
         $display("FAIL lw_count got=%0d want=%0d", instr_count, exp_cnt);
      end
   endtask

   task automatic test_sw_stall;
      logic [18:0] e[5];
      logic        mr[5];
      e  = '{V_FETCH, V_DEC, V_MADR, V_MWRST, V_MWR};
      mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      opcode = 6'b101011;
      for (int i = 0; i < 5; i++) begin
         mem_ready = mr[i];
         #1;
         checks++;
         if (obs !== e[i]) begin
            failures++;
            $display("FAIL sw_cycle%0d got=%b want=%b", i, obs, e[i]);
         end
         @(posedge clk);
         #1;
      end
      exp_cnt = exp_cnt + 1'b1;
      checks++;
      if (instr_count !== exp_cnt) begin
         failures++;
         $display("FAIL sw_count got=%0d want=%0d", instr_count, exp_cnt);
      end
   endtask

   task automatic test_reset_mid;
      opcode = 6'b100011;
      mem_ready = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      mem_ready = 1'b0;
      #1;
      checks++;
      if (obs !== V_MRD) begin
         failures++;
         $display("FAIL midreset_in_memrd got=%b want=%b", obs, V_MRD);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (obs !== V_ZERO) begin
         failures++;
         $display("FAIL midreset_outputs got=%b want=%b", obs, V_ZERO);
      end
      checks++;
      if (instr_count !== '0) begin
         failures++;
         $display("FAIL midreset_count got=%0d want=0", instr_count);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (obs !== V_FSTALL) begin
         failures++;
         $display("FAIL midreset_release got=%b want=%b", obs, V_FSTALL);
      end
      exp_cnt = '0;
   endtask

   task automatic test_beq;
      logic [18:0] e[3];
      for (int z = 1; z >= 0; z--) begin
         e = '{V_FETCH, V_DEC, (z == 1) ? V_BRZ : V_BRN};
         opcode = 6'b000100;
         mem_ready = 1'b1;
         zero = z[0];
         for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (obs !== e[i]) begin
               failures++;
               $display("FAIL beq_z%0d_cycle%0d got=%b want=%b", z, i, obs, e[i]);
            end
            @(posedge clk);
            #1;
         end
         exp_cnt = exp_cnt + 1'b1;
         checks++;
         if (instr_count !== exp_cnt) begin
            failures++;
            $display("FAIL beq_z%0d_count got=%0d want=%0d", z, instr_count, exp_cnt);
         end
      end
      zero = 1'b0;
   endtask

   task automatic test_illegal;
      logic [5:0] ops[2];
      logic [18:0] e[3];
      int n;
      ops = '{6'b111111, 6'b000010};
`ifdef MC_JUMP_EN
      n = 1;
`else
      n = 2;
`endif
      e = '{V_FETCH, V_DECILL, V_FSTALL};
      for (int k = 0; k < n; k++) begin
         opcode = ops[k];
         for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 0);
            #1;
            checks++;
            if (obs !== e[i]) begin
               failures++;
               $display("FAIL illegal_op%0d_cycle%0d got=%b want=%b", k, i, obs, e[i]);
            end
            @(posedge clk);
            #1;
         end
         checks++;
         if (instr_count !== exp_cnt) begin
            failures++;
            $display("FAIL illegal_op%0d_count got=%0d want=%0d", k, instr_count, exp_cnt);
         end
      end
   endtask

`ifdef MC_JUMP_EN
   task automatic test_jump;
      logic [18:0] e[3];
      e = '{V_FETCH, V_DEC, V_JMP};
      opcode = 6'b000010;
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (obs !== e[i]) begin
            failures++;
            $display("FAIL jump_cycle%0d got=%b want=%b", i, obs, e[i]);
         end
         @(posedge clk);
         #1;
      end
      exp_cnt = exp_cnt + 1'b1;
      checks++;
      if (instr_count !== exp_cnt) begin
         failures++;
         $display("FAIL jump_count got=%0d want=%0d", instr_count, exp_cnt);
      end
   endtask
`endif

   task automatic test_wrap;
      opcode = 6'b000000;
      mem_ready = 1'b1;
      while (exp_cnt != 4'hF) begin
         repeat (4) @(posedge clk);
         #1;
         exp_cnt = exp_cnt + 1'b1;
      end
      checks++;
      if (instr_count !== 4'hF) begin
         failures++;
         $display("FAIL wrap_full got=%0d want=15", instr_count);
      end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (instr_count !== 4'h0) begin
         failures++;
         $display("FAIL wrap_zero got=%0d want=0", instr_count);
      end
   endtask

   initial begin
      test_reset;
      test_rtype;
      test_lw_stall;
      test_reset_mid;
      test_beq;
      test_sw_stall;
      test_illegal;
`ifdef MC_JUMP_EN
      test_jump;
`endif
      test_wrap;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle datapath. Sequences fetch, decode, execute, memory and write-back for R-type, lw, sw, beq and j. Drives every datapath enable and mux select. Drives ALUOp into the ALU control block, which turns the 2-bit ALUOp plus the instruction funct into the 6-bit ALU function. Memory accesses stall on a ready handshake.

## Interface
- Parameters:
  - `CNT_W`, default 32: width of the retired-instruction counter.
- Ports:
  - `clk` in 1: the single clock.
  - `rst` in 1: reset, asynchronous and active-high.
  - `opcode` in 6: IR[31:26], valid from DECODE onward.
  - `zero` in 1: ALU zero flag.
  - `mem_ready` in 1: memory completes the current read/write this cycle.
  - `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA` out 1: standard multicycle controls.
  - `ALUSrcB` out 2: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
  - `ALUOp` out 2: 00 = add, 01 = subtract, 10 = R-type (decode funct).
  - `PCSource` out 2: 00 = ALU, 01 = ALUOut, 10 = jump target.
  - `pc_en` out 1: PCWrite | (PCWriteCond & zero).
  - `instr_done` out 1: one-cycle pulse in the last state of each instruction.
  - `illegal_op` out 1: one-cycle pulse in DECODE on an unsupported opcode.
  - `instr_count` out CNT_W: retired-instruction counter.

## Operation
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, j = 000010.
- Outputs are decoded from the state (Moore). The only exceptions are IRWrite and PCWrite in FETCH, which are gated by mem_ready. Any output not listed for a state is 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - If mem_ready: IRWrite=1, PCWrite=1, next state DECODE. Otherwise stay in FETCH.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state: lw/sw → MEMADR, R → EXEC, beq → BRANCH, j → JUMP.
  - Any other opcode: illegal_op=1, instr_done=0, next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw → MEMRD, sw → MEMWR.
- MEMRD: MemRead=1, IorD=1. Stay until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1, next FETCH.
- MEMWR: MemWrite=1, IorD=1. Stay until mem_ready; in the mem_ready cycle instr_done=1 and next state is FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10, next RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1, next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1, next FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1, next FETCH.
- instr_count:
  - Increments on every instr_done.
  - Wraps from all-ones to 0.
  - Illegal opcodes do not count.

## Timing
- Reset:
  - While rst is high: state = FETCH, instr_count = 0, all outputs 0. This includes MemRead and pc_en.
  - On the first clk edge after rst falls, FETCH outputs are active.
- Reset mid-instruction aborts the instruction immediately (asynchronous). No write enable stays asserted.
- Cycle counts with mem_ready always 1:
  - lw: 5 cycles.
  - sw, R-type: 4 cycles.
  - beq, j: 3 cycles.
  - illegal opcode: 2 cycles.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. Stalled cycles assert no write enable except MemWrite in MEMWR.
- mem_ready is ignored in every other state.
- opcode is sampled only in DECODE and MEMADR; it must be held stable from DECODE to instruction end.

## Configuration
- `MC_JUMP_EN`:
  - Defined: JUMP state present; j follows the 3-cycle path above.
  - Undefined: JUMP state absent; opcode 000010 is handled as illegal (illegal_op pulse, return to FETCH); PCSource never takes 10.

## Structure
- Shared package `cpu_defs_pkg` holds:
  - opcode constants;
  - ALUOp encodings (00 add, 01 sub, 10 R-type), also used by ALU control;
  - ALUSrcB and PCSource encodings;
  - the FSM state enum.
- One sub-module, `opcode_class`: combinational decode of opcode into {is_r, is_lw, is_sw, is_beq, is_j, is_illegal}. It honours `MC_JUMP_EN`.

## Test plan
- Reset: assert rst mid-MEMRD → all outputs 0 and instr_count=0 at once; release → FETCH with MemRead=1, ALUSrcB=01.
- R-type, opcode=000000, mem_ready=1 → states FETCH, DECODE, EXEC, RWB. ALUOp=10 in EXEC; RegWrite=1 with RegDst=1 in RWB; instr_count goes 0→1.
- lw with mem_ready low for 2 cycles in MEMRD → 7 cycles total. MEMRD holds MemRead=1, IorD=1; one MEMWB cycle with MemtoReg=1, RegWrite=1.
- beq: zero=1 → pc_en=1 and PCSource=01 in BRANCH. Repeat with zero=0 → pc_en=0 and instr_done still pulses.
- opcode=111111 → illegal_op pulses in DECODE, back in FETCH the next cycle, instr_count unchanged. With `MC_JUMP_EN` undefined, opcode=000010 gives the same response.
- Set instr_count to all-ones (CNT_W=4: 15 instructions), retire one more → wraps to 0.
